// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file / scoreboard.
// Defaults for width, register count, PC step and address-width derivation.
package regfile_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_PC_INC = 4;
    localparam int ZERO_REG   = 0;

    // Address width for a power-of-two register count (at least 1 bit).
    function automatic int calc_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: load has precedence over increment, otherwise hold.
// Ports: i_clk, i_rst (async high), i_en, i_load, i_load_val, o_pc.
module pc_counter #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_INC   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_val,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_en) begin
            // Wraps naturally modulo 2^XLEN.
            r_pc <= r_pc + XLEN'(PC_INC);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass, pending-write scoreboard and PC.
// Ports: CK_REF/RST, NRD packed read ports (RS_*), ISSUE_*, WB_*, PC_*.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              NREGS    = DEF_NREGS,
    parameter int              NRD      = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_INC   = DEF_PC_INC,
    localparam int             AW       = calc_aw(NREGS)
) (
    input  logic                CK_REF,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RS_ADDR,
    output logic [NRD*XLEN-1:0] RS_DATA,
    output logic [NRD-1:0]      RS_PENDING,
    input  logic                ISSUE_VALID,
    input  logic [AW-1:0]       ISSUE_RD,
    input  logic                WB_VALID,
    input  logic [AW-1:0]       WB_ADDR,
    input  logic [XLEN-1:0]     WB_DATA,
    input  logic                PC_EN,
    input  logic                PC_LOAD,
    input  logic [XLEN-1:0]     PC_LOAD_VAL,
    output logic [XLEN-1:0]     PC_OUT
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic             w_wb_we;
    logic             w_iss_we;

    assign w_wb_we  = WB_VALID && (WB_ADDR != ZR);
    assign w_iss_we = ISSUE_VALID && (ISSUE_RD != ZR);

    always_ff @(posedge CK_REF or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[WB_ADDR] <= WB_DATA;
        end
    end

    // Issue is applied after writeback so a same-register collision
    // leaves the bit set for the newer producer.
    always_comb begin
        w_pend_nxt = r_pend;
        if (WB_VALID) begin
            w_pend_nxt[WB_ADDR] = 1'b0;
        end
        if (w_iss_we) begin
            w_pend_nxt[ISSUE_RD] = 1'b1;
        end
        w_pend_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge CK_REF or posedge RST) begin
        if (RST) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_match;
        logic          w_byp;

        assign w_addr  = RS_ADDR[i*AW +: AW];
        assign w_match = WB_VALID && (WB_ADDR == w_addr);
        assign w_byp   = w_match && (w_addr != ZR);

        assign RS_DATA[i*XLEN +: XLEN] = w_byp ? WB_DATA : r_regs[w_addr];
        // Bit 0 of r_pend is never set, so x0 never reads pending.
        assign RS_PENDING[i] = r_pend[w_addr] && !w_match;
    end

    pc_counter #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc (
        .i_clk      (CK_REF),
        .i_rst      (RST),
        .i_en       (PC_EN),
        .i_load     (PC_LOAD),
        .i_load_val (PC_LOAD_VAL),
        .o_pc       (PC_OUT)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
// Default instance plus an NRD=3 / NREGS=16 instance for the bypass sweep.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;

    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_pend;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        wb_v;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        pc_en;
    logic        pc_ld;
    logic [31:0] pc_lv;
    logic [31:0] pc_out;

    logic [11:0] s_rs_addr;
    logic [95:0] s_rs_data;
    logic [2:0]  s_rs_pend;
    logic        s_wb_v;
    logic [3:0]  s_wb_a;
    logic [31:0] s_wb_d;
    logic [31:0] s_pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_scoreboard dut (
        .CK_REF      (clk),
        .RST         (rst),
        .RS_ADDR     (rs_addr),
        .RS_DATA     (rs_data),
        .RS_PENDING  (rs_pend),
        .ISSUE_VALID (iss_v),
        .ISSUE_RD    (iss_rd),
        .WB_VALID    (wb_v),
        .WB_ADDR     (wb_a),
        .WB_DATA     (wb_d),
        .PC_EN       (pc_en),
        .PC_LOAD     (pc_ld),
        .PC_LOAD_VAL (pc_lv),
        .PC_OUT      (pc_out)
    );

    regfile_scoreboard #(
        .NREGS (16),
        .NRD   (3)
    ) dut3 (
        .CK_REF      (clk),
        .RST         (rst),
        .RS_ADDR     (s_rs_addr),
        .RS_DATA     (s_rs_data),
        .RS_PENDING  (s_rs_pend),
        .ISSUE_VALID (1'b0),
        .ISSUE_RD    (4'd0),
        .WB_VALID    (s_wb_v),
        .WB_ADDR     (s_wb_a),
        .WB_DATA     (s_wb_d),
        .PC_EN       (1'b0),
        .PC_LOAD     (1'b0),
        .PC_LOAD_VAL (32'd0),
        .PC_OUT      (s_pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        p0;
        logic        p1;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        iss_v = 0; iss_rd = 0; wb_v = 0; wb_a = 0; wb_d = 0;
        pc_en = 0; pc_ld = 0; pc_lv = 0;
        s_wb_v = 0; s_wb_a = 0; s_wb_d = 0;
    endtask

    initial begin
        //        rs0 rs1 wv wa  wd             iv ird  d0            d1            p0 p1
        vt[0]  = '{3, 0, 1, 3, 32'h12345678, 0, 0, 32'h12345678, 32'h0,        0, 0};
        vt[1]  = '{3, 3, 0, 0, 32'h0,        0, 0, 32'h12345678, 32'h12345678, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h0,        32'h0,        0, 0};
        vt[3]  = '{0, 3, 0, 0, 32'h0,        0, 0, 32'h0,        32'h12345678, 0, 0};
        vt[4]  = '{9, 9, 0, 0, 32'h0,        1, 9, 32'h0,        32'h0,        0, 0};
        vt[5]  = '{9, 3, 0, 0, 32'h0,        0, 0, 32'h0,        32'h12345678, 1, 0};
        vt[6]  = '{9, 9, 1, 9, 32'hA5,       0, 0, 32'hA5,       32'hA5,       0, 0};
        vt[7]  = '{9, 0, 0, 0, 32'h0,        0, 0, 32'hA5,       32'h0,        0, 0};
        vt[8]  = '{9, 9, 1, 9, 32'h77,       1, 9, 32'h77,       32'h77,       0, 0};
        vt[9]  = '{9, 9, 0, 0, 32'h0,        0, 0, 32'h77,       32'h77,       1, 1};
        vt[10] = '{9, 4, 1, 9, 32'h88,       0, 0, 32'h88,       32'h0,        0, 0};
        vt[11] = '{9, 9, 0, 0, 32'h0,        0, 0, 32'h88,       32'h88,       0, 0};
        vt[12] = '{9, 0, 0, 0, 32'h0,        1, 9, 32'h88,       32'h0,        0, 0};
        vt[13] = '{9, 9, 1, 9, 32'h99,       1, 9, 32'h99,       32'h99,       0, 0};
        vt[14] = '{9, 3, 0, 0, 32'h0,        0, 0, 32'h99,       32'h12345678, 1, 0};
        vt[15] = '{9, 9, 1, 9, 32'h11,       0, 0, 32'h11,       32'h11,       0, 0};
        vt[16] = '{9, 0, 0, 0, 32'h0,        0, 0, 32'h11,       32'h0,        0, 0};

        rst = 1;
        idle();
        rs_addr = '0;
        s_rs_addr = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_d0", rs_data[31:0], 32'h0);
        chk("rst_pend", {30'd0, rs_pend}, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 17; i++) begin
            rs_addr = {vt[i].rs1, vt[i].rs0};
            wb_v = vt[i].wv; wb_a = vt[i].wa; wb_d = vt[i].wd;
            iss_v = vt[i].iv; iss_rd = vt[i].ird;
            #1;
            chk($sformatf("v%0d_d0", i), rs_data[31:0], vt[i].d0);
            chk($sformatf("v%0d_d1", i), rs_data[63:32], vt[i].d1);
            chk($sformatf("v%0d_p0", i), {31'd0, rs_pend[0]}, {31'd0, vt[i].p0});
            chk($sformatf("v%0d_p1", i), {31'd0, rs_pend[1]}, {31'd0, vt[i].p1});
            @(negedge clk);
        end
        idle();

        // PC: three increments from reset value.
        pc_en = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("pc_inc%0d", k), pc_out, 32'(4 * k));
        end
        pc_ld = 1; pc_lv = 32'h100;
        @(negedge clk);
        #1;
        chk("pc_load_prio", pc_out, 32'h100);
        pc_en = 0; pc_lv = 32'hFFFFFFFC;
        @(negedge clk);
        #1;
        chk("pc_load_top", pc_out, 32'hFFFFFFFC);
        pc_ld = 0; pc_en = 1;
        @(negedge clk);
        #1;
        chk("pc_wrap", pc_out, 32'h0);
        pc_en = 0;
        @(negedge clk);
        #1;
        chk("pc_hold", pc_out, 32'h0);

        // Mid-run reset: populate state, then reset between clock edges.
        wb_v = 1; wb_a = 5; wb_d = 32'hDEADBEEF;
        iss_v = 1; iss_rd = 7; pc_en = 1;
        @(negedge clk);
        idle();
        rs_addr = {5'd7, 5'd5};
        #1;
        chk("pre_rst_x5", rs_data[31:0], 32'hDEADBEEF);
        chk("pre_rst_p7", {31'd0, rs_pend[1]}, 32'h1);
        chk("pre_rst_pc", pc_out, 32'h4);
        #1;
        rst = 1;
        #1;
        chk("mid_rst_x5", rs_data[31:0], 32'h0);
        chk("mid_rst_pend", {30'd0, rs_pend}, 32'h0);
        chk("mid_rst_pc", pc_out, 32'h0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_x5", rs_data[31:0], 32'h0);

        // Three-port sweep: all ports on the register being written.
        @(negedge clk);
        s_rs_addr = {4'd15, 4'd15, 4'd15};
        s_wb_v = 1; s_wb_a = 15; s_wb_d = 32'hCAFEF00D;
        #1;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("sw_byp%0d", p), s_rs_data[p*32 +: 32], 32'hCAFEF00D);
        end
        @(negedge clk);
        s_wb_v = 0;
        s_rs_addr = {4'd0, 4'd15, 4'd2};
        #1;
        chk("sw_arr0", s_rs_data[31:0], 32'h0);
        chk("sw_arr1", s_rs_data[63:32], 32'hCAFEF00D);
        chk("sw_arr2", s_rs_data[95:64], 32'h0);
        chk("sw_pc", s_pc_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
